// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the system RAM bus arbiter.
// Requester indices name the fixed slots on the req/gnt vectors.
package mem_bus_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int MEM_ADDR_W = 8;
  localparam int MEM_DATA_W = 8;
  localparam int OWNER_W    = 2;

  localparam int REQ_CPU    = 0;
  localparam int REQ_LOADER = 1;
  localparam int REQ_DMA    = 2;

endpackage

// File: rtl/mem_bus_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or after ptr,
// wrapping modulo NUM_REQ.
module rr_pick
  import mem_bus_pkg::*;
#(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [OWNER_W-1:0] ptr,
  output logic [NUM_REQ-1:0] choice,
  output logic [OWNER_W-1:0] choice_idx,
  output logic               found
);

  int idx;

  always_comb begin
    choice     = '0;
    choice_idx = '0;
    found      = 1'b0;
    idx        = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        found       = 1'b1;
        choice[idx] = 1'b1;
        choice_idx  = OWNER_W'(idx);
      end
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter owning the single-port system RAM: one grant at a time,
// locked bursts capped at MAX_BURST beats while someone else is waiting.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int NUM_REQ   = 3,
  parameter int ADDR_W    = MEM_ADDR_W,
  parameter int DATA_W    = MEM_DATA_W,
  parameter int MAX_BURST = 4
) (
  input  logic                      clk,
  input  logic                      reset_cycle,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        lock,
  input  logic [NUM_REQ-1:0]        we,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        ack,
  output logic [DATA_W-1:0]         rdata,
  output logic [OWNER_W-1:0]        owner,
  output logic                      busy,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata,
  output arb_state_e                state_dbg
);

  // Handshake: a requester raises req and holds it until its access has
  // happened; the access happens in any cycle where it owns gnt with req=1,
  // and ack pulses in the following cycle together with valid rdata.

  localparam int                BEAT_W    = 4;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(MAX_BURST - 1);

  arb_state_e           state, state_nxt;
  logic [NUM_REQ-1:0]   gnt_q;
  logic [OWNER_W-1:0]   owner_q;
  logic [OWNER_W-1:0]   rr_ptr;
  logic [BEAT_W-1:0]    beat_cnt;
  logic [NUM_REQ-1:0]   ack_q;
  logic                 ack_rd_q;
  logic [DATA_W-1:0]    rdata_q;
  logic [ADDR_W-1:0]    last_addr_q;
  logic [DATA_W-1:0]    last_wdata_q;

  logic [NUM_REQ-1:0]   pick_oh;
  logic [OWNER_W-1:0]   pick_idx;
  logic                 pick_found;

  logic                 owner_req;
  logic                 owner_lock;
  logic                 owner_we;
  logic [ADDR_W-1:0]    owner_addr;
  logic [DATA_W-1:0]    owner_wdata;
  logic                 access;
  logic                 others_waiting;
  logic                 release_now;

  rr_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_rr_pick (
    .req       (req),
    .ptr       (rr_ptr),
    .choice    (pick_oh),
    .choice_idx(pick_idx),
    .found     (pick_found)
  );

  always_comb begin
    owner_req   = 1'b0;
    owner_lock  = 1'b0;
    owner_we    = 1'b0;
    owner_addr  = '0;
    owner_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_q == OWNER_W'(i)) begin
        owner_req   = req[i];
        owner_lock  = lock[i];
        owner_we    = we[i];
        owner_addr  = addr[i*ADDR_W +: ADDR_W];
        owner_wdata = wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign access         = (state == GRANT) && owner_req;
  assign others_waiting = |(req & ~gnt_q);
  // Forced release on the capped beat stops a locked owner starving the rest.
  assign release_now    = !access || !owner_lock ||
                          ((beat_cnt == BEAT_LAST) && others_waiting);

  always_ff @(posedge clk or posedge reset_cycle) begin
    if (reset_cycle) state <= IDLE;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_found) state_nxt = GRANT;
      GRANT:   if (release_now) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == GRANT);
    gnt       = gnt_q;
    owner     = owner_q;
    ack       = ack_q;
    mem_en    = access;
    mem_we    = access && owner_we;
    mem_addr  = access ? owner_addr  : last_addr_q;
    mem_wdata = access ? owner_wdata : last_wdata_q;
    rdata     = ack_rd_q ? mem_rdata : rdata_q;
    state_dbg = state;
  end

  always_ff @(posedge clk or posedge reset_cycle) begin
    if (reset_cycle) begin
      gnt_q    <= '0;
      owner_q  <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            gnt_q    <= pick_oh;
            owner_q  <= pick_idx;
            beat_cnt <= '0;
          end
        end
        GRANT: begin
          if (access && (beat_cnt != BEAT_LAST)) beat_cnt <= beat_cnt + 1'b1;
          if (release_now) begin
            gnt_q  <= '0;
            rr_ptr <= (owner_q == OWNER_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
          end
        end
        default: gnt_q <= '0;
      endcase
    end
  end

  // Ack follows the access by one cycle, matching the RAM's read latency.
  always_ff @(posedge clk or posedge reset_cycle) begin
    if (reset_cycle) begin
      ack_q    <= '0;
      ack_rd_q <= 1'b0;
    end else begin
      ack_q    <= access ? gnt_q : '0;
      ack_rd_q <= access && !owner_we;
    end
  end

  always_ff @(posedge clk or posedge reset_cycle) begin
    if (reset_cycle) rdata_q <= '0;
    else if (ack_rd_q) rdata_q <= mem_rdata;
  end

  always_ff @(posedge clk or posedge reset_cycle) begin
    if (reset_cycle) begin
      last_addr_q  <= '0;
      last_wdata_q <= '0;
    end else if (access) begin
      last_addr_q  <= owner_addr;
      last_wdata_q <= owner_wdata;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: requester agents, a RAM model, and a
// transaction-level reference model with a read-data expectation queue.
module tb_mem_bus_arbiter;
  import mem_bus_pkg::*;

  localparam int N         = 3;
  localparam int AW        = 8;
  localparam int DW        = 8;
  localparam int MAX_BURST = 4;

  logic              clk = 1'b0;
  logic              reset_cycle = 1'b1;
  logic [N-1:0]      req, lock, we;
  logic [N*AW-1:0]   addr;
  logic [N*DW-1:0]   wdata;
  logic [N-1:0]      gnt, ack;
  logic [DW-1:0]     rdata;
  logic [OWNER_W-1:0] owner;
  logic              busy, mem_en, mem_we;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata, mem_rdata;
  arb_state_e        state_dbg;

  mem_bus_arbiter #(
    .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk(clk), .reset_cycle(reset_cycle), .req(req), .lock(lock), .we(we),
    .addr(addr), .wdata(wdata), .gnt(gnt), .ack(ack), .rdata(rdata),
    .owner(owner), .busy(busy), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / RAM ----------------
  always #5 clk = ~clk;

  logic [DW-1:0] ram [256];
  logic          pre_en;
  logic [7:0]    pre_a, pre_d;

  always @(posedge clk) begin
    if (pre_en) ram[pre_a] <= pre_d;
    else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  // ---------------- model / agent state ----------------
  logic [7:0]    shadow [256];
  logic [DW-1:0] exp_q[$];
  bit            m_busy;
  int            m_owner, m_ptr, m_beats, acc_idx;
  logic [N-1:0]  m_ack;
  bit            m_ack_rd;
  logic [7:0]    m_last_addr, m_last_wdata, m_rdata_hold;

  logic [N-1:0]    p_req, p_lock, p_we;
  logic [N*AW-1:0] p_addr;
  logic [N*DW-1:0] p_wdata;

  bit         a_req [N];
  bit         a_lock [N];
  bit         a_we [N];
  logic [7:0] a_addr [N];
  logic [7:0] a_wdata [N];
  int         a_left [N];
  bit         rand_en;

  int gnt_log[$];
  int beats_log[$];
  bit o_prev_busy;
  int o_beats, ack_cnt;
  int n_checks, n_fail;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] sl(logic [N*8-1:0] v, int i);
    return v[i*8 +: 8];
  endfunction

  function automatic logic [7:0] pre_val(int a);
    return (a == 16) ? 8'hA5 : (8'(a) ^ 8'h5A);
  endfunction

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_ptr = 0; m_beats = 0; acc_idx = -1;
    m_ack = '0; m_ack_rd = 0;
    m_last_addr = '0; m_last_wdata = '0; m_rdata_hold = '0;
    exp_q.delete();
  endtask

  // Advance the reference model across one clock edge using the inputs
  // that were present during the cycle that just ended.
  task automatic model_edge();
    logic [7:0]   a;
    logic [N-1:0] mine;
    bit           others, rel;
    acc_idx = -1; m_ack = '0; m_ack_rd = 0;
    if (m_busy && p_req[m_owner]) begin
      acc_idx = m_owner;
      m_ack[m_owner] = 1'b1;
      m_ack_rd = !p_we[m_owner];
      a = sl(p_addr, m_owner);
      if (p_we[m_owner]) shadow[a] = sl(p_wdata, m_owner);
      else exp_q.push_back(shadow[a]);
      m_last_addr  = a;
      m_last_wdata = sl(p_wdata, m_owner);
    end
    if (!m_busy) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (!m_busy && p_req[c]) begin
          m_busy = 1; m_owner = c; m_beats = 0;
        end
      end
    end else begin
      mine = '0; mine[m_owner] = 1'b1;
      others = (p_req & ~mine) != '0;
      rel = (acc_idx < 0) || !p_lock[m_owner] ||
            ((m_beats >= MAX_BURST - 1) && others);
      if (acc_idx >= 0) m_beats++;
      if (rel) begin
        m_busy = 0;
        m_ptr  = (m_owner + 1) % N;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic start_txn(int i, logic [7:0] ad, bit w, logic [7:0] d, int beats);
    a_req[i] = 1; a_we[i] = w; a_addr[i] = ad; a_wdata[i] = d;
    a_left[i] = beats - 1; a_lock[i] = (beats > 1);
  endtask

  task automatic agent_update();
    for (int i = 0; i < N; i++) begin
      if (acc_idx == i) begin
        if (a_left[i] > 0) begin
          a_left[i]--; a_addr[i]++; a_wdata[i]++;
          a_lock[i] = (a_left[i] > 0);
        end else begin
          a_req[i] = 0; a_lock[i] = 0;
        end
      end
    end
    if (rand_en) begin
      for (int i = 0; i < N; i++) begin
        if (!a_req[i]) begin
          if ($urandom_range(0, 3) == 0)
            start_txn(i, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                      8'($urandom_range(0, 255)), int'($urandom_range(1, 6)));
        end else if (!(m_busy && m_owner == i) && $urandom_range(0, 15) == 0) begin
          a_req[i] = 0; a_lock[i] = 0; a_left[i] = 0;
        end
      end
    end
  endtask

  task automatic pack();
    for (int i = 0; i < N; i++) begin
      req[i] = a_req[i]; lock[i] = a_lock[i]; we[i] = a_we[i];
      addr[i*AW +: AW]  = a_addr[i];
      wdata[i*DW +: DW] = a_wdata[i];
    end
  endtask

  task automatic save_prev();
    p_req = req; p_lock = lock; p_we = we; p_addr = addr; p_wdata = wdata;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check_all();
    logic [N-1:0] exp_gnt;
    bit           acc;
    exp_gnt = '0;
    if (m_busy) exp_gnt[m_owner] = 1'b1;
    acc = m_busy && req[m_owner];
    check("gnt", 32'(gnt), 32'(exp_gnt));
    check("busy", 32'(busy), 32'(m_busy));
    check("state", 32'(state_dbg), m_busy ? 32'(GRANT) : 32'(IDLE));
    if (m_busy) check("owner", 32'(owner), m_owner);
    check("mem_en", 32'(mem_en), 32'(acc));
    check("mem_we", 32'(mem_we), 32'(acc && we[m_owner]));
    check("mem_addr", 32'(mem_addr), 32'(acc ? sl(addr, m_owner) : m_last_addr));
    check("mem_wdata", 32'(mem_wdata), 32'(acc ? sl(wdata, m_owner) : m_last_wdata));
    check("ack", 32'(ack), 32'(m_ack));
    if (m_ack_rd && exp_q.size() > 0) m_rdata_hold = exp_q.pop_front();
    check("rdata", 32'(rdata), 32'(m_rdata_hold));
    if (busy && !o_prev_busy) begin gnt_log.push_back(int'(owner)); o_beats = 0; end
    if (mem_en) o_beats++;
    if (!busy && o_prev_busy) beats_log.push_back(o_beats);
    o_prev_busy = busy;
    if (ack != '0) ack_cnt++;
  endtask

  task automatic tick();
    @(posedge clk); #1;
    if (!reset_cycle) model_edge();
    agent_update();
  endtask

  task automatic drive_and_check();
    pack(); #1;
    check_all();
    save_prev();
  endtask

  task automatic run(int n);
    repeat (n) begin tick(); drive_and_check(); end
  endtask

  function automatic bit any_req();
    for (int i = 0; i < N; i++) if (a_req[i]) return 1;
    return 0;
  endfunction

  task automatic wait_idle();
    int cnt;
    cnt = 0;
    while ((any_req() || m_busy || m_ack != '0) && cnt < 300) begin
      tick(); drive_and_check(); cnt++;
    end
    check("idle_timeout", 32'(cnt >= 300), 0);
  endtask

  task automatic clear_logs();
    gnt_log.delete(); beats_log.delete(); ack_cnt = 0;
  endtask

  task automatic check_seq(string tag, bit use_beats, int n, int e0 = 0, int e1 = 0, int e2 = 0);
    int e [3];
    int sz;
    e[0] = e0; e[1] = e1; e[2] = e2;
    sz = use_beats ? beats_log.size() : gnt_log.size();
    check({tag, "_len"}, sz, n);
    for (int i = 0; i < sz && i < n; i++)
      check(tag, use_beats ? beats_log[i] : gnt_log[i], e[i]);
  endtask

  // Asserted mid-cycle so the asynchronous clear is observed before any edge.
  task automatic do_reset();
    #2;
    reset_cycle = 1'b1;
    for (int i = 0; i < N; i++) begin a_req[i] = 0; a_lock[i] = 0; a_left[i] = 0; end
    pack(); #1;
    model_reset();
    check_all();
    check("rst_mem_en", 32'(mem_en), 0);
    repeat (2) @(posedge clk);
    #3;
    reset_cycle = 1'b0;
    save_prev();
    o_prev_busy = 0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int loops;
    n_checks = 0; n_fail = 0; rand_en = 0;
    pre_en = 0; pre_a = '0; pre_d = '0;
    for (int i = 0; i < N; i++) begin
      a_req[i] = 0; a_lock[i] = 0; a_we[i] = 0; a_addr[i] = '0; a_wdata[i] = '0; a_left[i] = 0;
    end
    pack(); save_prev(); model_reset(); clear_logs();
    o_prev_busy = 0; o_beats = 0;
    #1;
    check_all();
    pre_en = 1;
    for (int a = 0; a < 256; a++) begin
      pre_a = 8'(a); pre_d = pre_val(a); shadow[a] = pre_val(a);
      @(posedge clk); #1;
    end
    pre_en = 0;
    check_all();
    @(posedge clk); #3;
    reset_cycle = 1'b0;
    save_prev();

    // Single CPU read of the preloaded location.
    clear_logs();
    start_txn(REQ_CPU, 8'h10, 0, 8'h00, 1);
    wait_idle();
    check_seq("t1_gnt", 0, 1, 0);
    check_seq("t1_beats", 1, 1, 1);
    check("t1_rdata", 32'(rdata), 32'hA5);

    // Pointer now sits after the CPU: 2 wins over 0.
    clear_logs();
    start_txn(REQ_CPU, 8'h11, 0, 8'h00, 1);
    start_txn(REQ_DMA, 8'h12, 0, 8'h00, 1);
    wait_idle();
    check_seq("t1_ptr", 0, 2, 2, 0);

    // All three at once after reset.
    do_reset();
    clear_logs();
    for (int i = 0; i < N; i++) start_txn(i, 8'(8'h30 + i), 0, 8'h00, 1);
    wait_idle();
    check_seq("t2_gnt", 0, 3, 0, 1, 2);
    check_seq("t2_beats", 1, 3, 1, 1, 1);

    // Locked burst with no competition.
    clear_logs();
    start_txn(REQ_LOADER, 8'h20, 1, 8'h01, 6);
    wait_idle();
    check_seq("t3_gnt", 0, 1, 1);
    check_seq("t3_beats", 1, 1, 6);
    check("t3_acks", ack_cnt, 6);
    for (int k = 0; k < 6; k++) check("t3_ram", 32'(ram[8'(8'h20 + k)]), k + 1);

    // Forced release of a long CPU burst while the DMA waits.
    clear_logs();
    start_txn(REQ_CPU, 8'h60, 1, 8'h10, 8);
    tick(); drive_and_check();
    tick();
    start_txn(REQ_DMA, 8'h70, 0, 8'h00, 1);
    drive_and_check();
    wait_idle();
    check_seq("t4_gnt", 0, 3, 0, 2, 0);
    check_seq("t4_beats", 1, 3, 4, 1, 4);

    // Request withdrawn in the cycle it is granted.
    clear_logs();
    tick();
    start_txn(REQ_LOADER, 8'h40, 0, 8'h00, 1);
    drive_and_check();
    tick();
    a_req[REQ_LOADER] = 0;
    drive_and_check();
    run(3);
    check_seq("t5_gnt", 0, 1, 1);
    check_seq("t5_beats", 1, 1, 0);
    check("t5_acks", ack_cnt, 0);

    // Reset during the DMA's third write beat.
    clear_logs();
    start_txn(REQ_DMA, 8'h80, 1, 8'h30, 6);
    loops = 0;
    while (!(busy && o_beats == 3) && loops < 50) begin
      tick(); drive_and_check(); loops++;
    end
    check("t6_reach_beat3", 32'(loops >= 50), 0);
    do_reset();
    ack_cnt = 0;
    run(4);
    check("t6_no_ack", ack_cnt, 0);
    check("t6_ram_b2", 32'(ram[8'h81]), 32'h31);
    check("t6_ram_b3", 32'(ram[8'h82]), 32'(pre_val(8'h82)));
    clear_logs();
    start_txn(REQ_DMA, 8'h90, 0, 8'h00, 1);
    start_txn(REQ_LOADER, 8'h91, 0, 8'h00, 1);
    wait_idle();
    check_seq("t6_gnt", 0, 2, 1, 2);

    // Randomized traffic with a reset in the middle.
    rand_en = 1;
    run(1500);
    do_reset();
    run(1500);
    rand_en = 0;
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single-port 8-bit system RAM between NUM_REQ requesters: the CPU fetch/execute path, the program loader and the output/display DMA.
- Owns the RAM address/data/write-enable lines, grants one requester at a time with round-robin fairness, and supports locked bursts such as PUSH/CALL sequences.
- Sits between the requesters and the RAM macro; the RAM has a registered read with 1-cycle latency.

Parameters:
- NUM_REQ, 3, number of requesters; index 0 is the CPU.
- ADDR_W, 8, RAM address width.
- DATA_W, 8, RAM data width.
- MAX_BURST, 4, maximum accesses per grant while another requester waits; range 1..15.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_cycle  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  per-requester access request, held until ack.
- lock  in  NUM_REQ  keep grant after current access (burst).
- we  in  NUM_REQ  1 = write, 0 = read.
- addr  in  NUM_REQ*ADDR_W  packed addresses; slice i belongs to requester i.
- wdata  in  NUM_REQ*DATA_W  packed write data.
- gnt  out  NUM_REQ  one-hot registered grant.
- ack  out  NUM_REQ  one-cycle pulse: the access completed (read data valid).
- rdata  out  DATA_W  read data, valid in the cycle ack is high.
- owner  out  2  index of the current grant holder; valid when busy=1.
- busy  out  1  a grant is held.
- mem_en  out  1  RAM access strobe.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data, 1 cycle after mem_en.

Behaviour:
- Reset values: gnt=0, ack=0, rdata=0, owner=0, busy=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0. Reset also clears beat_cnt=0 and rr_ptr=0. Reset mid-burst drops the grant and any pending ack; the RAM sees no strobe after reset asserts.
- FSM states:
  - IDLE: busy=0.
  - GRANT: busy=1, gnt[owner]=1.
- IDLE -> GRANT: when any req bit is set, select the first requester at or after rr_ptr (wrapping modulo NUM_REQ). On that clock edge: gnt, owner and busy are registered, and beat_cnt=0.
  - Arbitration latency is 1 cycle: req rises in cycle N, gnt is visible in N+1, and the first access may occur in N+1.
- Access cycle: any cycle in GRANT with req[owner]=1.
  - mem_en=1, and mem_we/mem_addr/mem_wdata are driven combinationally from the owner's slices.
  - Outside an access cycle: mem_en=0, mem_we=0, and the other mem outputs hold their last values.
- Ack: registered, asserted exactly one cycle after each access cycle. rdata captures mem_rdata in that ack cycle and holds otherwise.
  - Writes also ack; rdata is then undefined (implementation holds the previous value).
- beat_cnt: increments on each access cycle and saturates at MAX_BURST-1.
- Release GRANT -> IDLE on the edge ending a cycle where any of these holds:
  - (a) no access occurred (req[owner]=0);
  - (b) an access occurred with lock[owner]=0;
  - (c) an access occurred with beat_cnt==MAX_BURST-1 while another req bit is set (forced release; prevents starvation).
- Without competing requests, a locked owner keeps the grant indefinitely.
- On release, rr_ptr = (owner+1) mod NUM_REQ. There is always one IDLE bubble cycle between grants.
- The ack of the last access is still issued in the bubble cycle after release.
- Simultaneous requests in IDLE resolve strictly by rr_ptr order. A request arriving mid-burst waits for release.
- A requester may drop req while not granted with no effect. It must not change addr/we/wdata in a cycle it is granted with req=1.
- Invariants: gnt is one-hot or zero; mem_en is never high in IDLE; ack is one-hot or zero.

Decomposition:
- Shared package mem_bus_pkg: the state enum (IDLE, GRANT), MEM_ADDR_W/MEM_DATA_W constants, and requester index constants REQ_CPU=0, REQ_LOADER=1, REQ_DMA=2.
- One sub-module, rr_pick: combinational round-robin selector (req vector + rr_ptr -> one-hot choice + index). Everything else lives in mem_bus_arbiter.

Test Plan:
- Single CPU read: preload RAM[0x10]=0xA5; req[0]=1, we=0, addr=0x10, lock=0 -> gnt[0] next cycle, mem_en one cycle, ack[0] one cycle later with rdata=0xA5, then busy=0 and rr_ptr=1.
- Simultaneous req=3'b111 after reset -> grants in order 0,1,2, each for one access, with one IDLE bubble between grants; gnt never has two bits set.
- Locked burst alone: requester 1 with lock=1 writes 0x01..0x06 to addr 0x20..0x25 -> six consecutive access cycles in one grant, six acks, RAM contents verified.
- Forced release: requester 0 locked burst with req[2] pending, MAX_BURST=4 -> exactly 4 accesses, release, then gnt[2]; requester 0 regains the grant only after requester 2 finishes.
- Reset mid-burst: assert reset_cycle during requester 2's third beat -> gnt, ack, mem_en and busy go 0 immediately; no ack appears after reset releases; the next grant starts from rr_ptr=0.
- Request withdrawn: req[1] pulses for one cycle in IDLE, then drops -> gnt[1] for one cycle, no mem_en, no ack, release to IDLE.
